// File: rtl/iic_req_arbiter_if.sv
// Requester and IIC-master side signals of the arbiter, bundled with one modport per side.
interface iic_req_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] req_wr;
    logic [N_REQ-1:0] gnt;
    logic             done;
    logic [1:0]       status;
    logic             iic_wr_trig_n;
    logic             iic_rd_trig_n;
    logic             iic_busy;
    logic             iic_ack_error;

    modport master (
        output req, req_wr, iic_busy, iic_ack_error,
        input  gnt, done, status, iic_wr_trig_n, iic_rd_trig_n
    );

    modport slave (
        input  req, req_wr, iic_busy, iic_ack_error,
        output gnt, done, status, iic_wr_trig_n, iic_rd_trig_n
    );
endinterface

// File: rtl/iic_req_arbiter.sv
// Round-robin arbiter sharing one IIC EEPROM master: one trigger per grant, busy/ack tracking,
// post-write gap, and a done pulse with status per grant.
module iic_req_arbiter #(
    parameter int N_REQ         = 4,
    parameter int TRIG_HOLD     = 1_000_000,
    parameter int START_TIMEOUT = 2_000_000,
    parameter int XFER_TIMEOUT  = 200_000,
    parameter int WR_GAP        = 250_000
) (
    input  logic               clk_50M,
    input  logic               rst,
    iic_req_arbiter_if.slave   bus
);
    localparam int M1      = (TRIG_HOLD > START_TIMEOUT) ? TRIG_HOLD : START_TIMEOUT;
    localparam int M2      = (XFER_TIMEOUT > WR_GAP) ? XFER_TIMEOUT : WR_GAP;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(N_REQ);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_BUSY, WAIT_DONE, GAP, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [RW-1:0]    rr;
    logic [N_REQ-1:0] gnt;
    logic             done;
    logic [1:0]       status;
    logic             op;
    logic             busy_seen;
    logic             wr_trig_n;
    logic             rd_trig_n;

    logic [RW-1:0]    win;
    logic [RW-1:0]    cand;
    logic             any;

    // First active requester after the last winner, wrapping past N_REQ-1.
    always_comb begin
        win  = rr;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = RW'((32'(rr) + i) % 32'(N_REQ));
            if (!any && bus.req[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rr        <= RW'(N_REQ - 1);
            gnt       <= '0;
            done      <= 1'b0;
            status    <= 2'b00;
            op        <= 1'b0;
            busy_seen <= 1'b0;
            wr_trig_n <= 1'b1;
            rd_trig_n <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                        op        <= bus.req_wr[win];
                        rr        <= win;
                        cnt       <= '0;
                        busy_seen <= 1'b0;
                        if (bus.req_wr[win]) wr_trig_n <= 1'b0;
                        else                 rd_trig_n <= 1'b0;
                        state     <= TRIG;
                    end
                end
                TRIG: begin
                    if (bus.iic_busy) busy_seen <= 1'b1;
                    if (cnt == CW'(TRIG_HOLD - 1)) begin
                        wr_trig_n <= 1'b1;
                        rd_trig_n <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT_BUSY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (busy_seen || bus.iic_busy) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else if (cnt == CW'(START_TIMEOUT - 1)) begin
                        status <= 2'b10;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    // Only a clean write goes through GAP, so its status is always ok.
                    if (!bus.iic_busy) begin
                        if (op && !bus.iic_ack_error) begin
                            cnt   <= '0;
                            state <= GAP;
                        end else begin
                            status <= {1'b0, bus.iic_ack_error};
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end else if (cnt == CW'(XFER_TIMEOUT - 1)) begin
                        status <= 2'b11;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == CW'(WR_GAP - 1)) begin
                        status <= 2'b00;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt           = gnt;
    assign bus.done          = done;
    assign bus.status        = status;
    assign bus.iic_wr_trig_n = wr_trig_n;
    assign bus.iic_rd_trig_n = rd_trig_n;
endmodule

// File: tb/tb_iic_req_arbiter.sv
// Randomized scoreboard bench for iic_req_arbiter with a behavioural IIC master model.
module tb_iic_req_arbiter;
    localparam int N_REQ         = 2;
    localparam int TRIG_HOLD     = 4;
    localparam int START_TIMEOUT = 16;
    localparam int XFER_TIMEOUT  = 64;
    localparam int WR_GAP        = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iic_req_arbiter_if #(.N_REQ(N_REQ)) bus ();

    iic_req_arbiter #(
        .N_REQ(N_REQ), .TRIG_HOLD(TRIG_HOLD), .START_TIMEOUT(START_TIMEOUT),
        .XFER_TIMEOUT(XFER_TIMEOUT), .WR_GAP(WR_GAP)
    ) dut (
        .clk_50M(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [1:0]  gnt;
        logic        wr;
        logic [1:0]  status;
        int unsigned gc;
        int unsigned dc;
    } exp_t;

    exp_t        q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned m_rr     = N_REQ - 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic note_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
    endtask

    // Master model: busy rises m_d cycles after the trigger first goes low, lasts m_l cycles.
    bit          m_never = 0, m_stuck = 0, m_ack = 0;
    int unsigned m_d = 2, m_l = 30;
    bit          m_active = 0, m_prev_low = 0;
    int unsigned m_g0 = 0;

    always @(posedge clk) begin : master_model
        bit low;
        low = !(bus.iic_wr_trig_n && bus.iic_rd_trig_n);
        if (bus.done || rst) m_active = 0;
        if (low && !m_prev_low && !rst) begin
            m_active = 1;
            m_g0     = cyc;
        end
        m_prev_low = low;
        if (rst) begin
            bus.iic_busy      <= 1'b0;
            bus.iic_ack_error <= 1'b0;
        end else begin
            if (m_active && !m_never && (cyc + 1) >= m_g0 + m_d &&
                (m_stuck || (cyc + 1) < m_g0 + m_d + m_l))
                bus.iic_busy <= 1'b1;
            else
                bus.iic_busy <= 1'b0;
            if (m_active && (cyc + 1) == m_g0 + m_d) bus.iic_ack_error <= m_ack;
        end
    end

    // Transaction outcome from the grant cycle g and the master behaviour.
    function automatic int unsigned exp_done(input int unsigned g, input bit wr, input int typ,
                                             input int unsigned d, input int unsigned l,
                                             input bit ack, output logic [1:0] st);
        int unsigned w, r, wd, f, e;
        w = g + TRIG_HOLD;
        if (typ == 1) begin
            st = 2'b10;
            return w + START_TIMEOUT;
        end
        r  = g + d;
        wd = ((r > w) ? r : w) + 1;
        if (typ == 2) begin
            st = 2'b11;
            return wd + XFER_TIMEOUT;
        end
        f = r + l;
        e = (f > wd) ? f : wd;
        if (e >= wd + XFER_TIMEOUT) begin
            st = 2'b11;
            return wd + XFER_TIMEOUT;
        end
        st = {1'b0, ack};
        return (wr && !ack) ? e + 1 + WR_GAP : e + 1;
    endfunction

    // typ: 0 normal, 1 master never busy, 2 master stuck busy.
    task automatic run_txn(input logic [1:0] r, input logic [1:0] w, input int typ,
                           input int unsigned d, input int unsigned l, input bit ack,
                           input bit after, input bit scramble, input int unsigned abort_at);
        exp_t        e;
        int unsigned win;
        bit          got;
        win = m_rr;
        for (int i = 1; i <= N_REQ; i++) begin
            int unsigned idx;
            idx = (m_rr + i) % N_REQ;
            if (r[idx]) begin
                win = idx;
                break;
            end
        end
        m_rr    = win;
        m_never = (typ == 1);
        m_stuck = (typ == 2);
        m_d     = d;
        m_l     = l;
        m_ack   = ack;
        bus.req    = r;
        bus.req_wr = w;
        e.gnt = (win == 0) ? 2'b01 : 2'b10;
        e.wr  = w[win];
        e.gc  = cyc + (after ? 2 : 1);
        e.dc  = exp_done(e.gc, e.wr, typ, d, l, ack, e.status);
        q.push_back(e);

        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            note_fail("gnt_timeout");
            q.delete();
            return;
        end

        if (abort_at != 0) begin
            repeat (abort_at) @(negedge clk);
            rst     = 1'b1;
            bus.req = '0;
            q.delete();
            m_rr = N_REQ - 1;
            @(posedge clk);
            #1;
            check("rst_gnt", int'(bus.gnt), 0);
            check("rst_trig", int'({bus.iic_wr_trig_n, bus.iic_rd_trig_n}), 3);
            check("rst_done", int'(bus.done), 0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            return;
        end

        if (scramble) begin
            bus.req    = 2'($urandom_range(0, 3));
            bus.req_wr = 2'($urandom_range(0, 3));
        end

        got = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            note_fail("done_timeout");
            q.delete();
        end
    endtask

    // Monitor: invariants every cycle, trigger pulse shape, grant timing, done pop/compare.
    int unsigned run = 0;
    bit          kind = 0;
    logic [1:0]  pg = '0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                run = 0;
                pg  = '0;
            end else begin
                check("excl", int'($countones(bus.gnt) <= 1 &&
                                   (bus.iic_wr_trig_n || bus.iic_rd_trig_n)), 1);
                if (!(bus.iic_wr_trig_n && bus.iic_rd_trig_n)) begin
                    if (run == 0) kind = !bus.iic_wr_trig_n;
                    run++;
                end else if (run != 0) begin
                    check("trig_len", int'(run), TRIG_HOLD);
                    if (q.size() != 0) check("trig_kind", int'(kind), int'(q[0].wr));
                    else note_fail("trig_unexpected");
                    run = 0;
                end
                if (pg == 0 && bus.gnt != 0) begin
                    if (q.size() == 0) note_fail("gnt_unexpected");
                    else begin
                        check("gnt_val", int'(bus.gnt), int'(q[0].gnt));
                        check("gnt_cycle", int'(cyc), int'(q[0].gc));
                    end
                end
                pg = bus.gnt;
                if (bus.done) begin
                    if (q.size() == 0) note_fail("done_unexpected");
                    else begin
                        e = q.pop_front();
                        check("done_gnt", int'(bus.gnt), int'(e.gnt));
                        check("done_status", int'(bus.status), int'(e.status));
                        check("done_cycle", int'(cyc), int'(e.dc));
                        check("done_trig", int'({bus.iic_wr_trig_n, bus.iic_rd_trig_n}), 3);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req    = '0;
        bus.req_wr = '0;
        repeat (3) @(negedge clk);
        check("reset_gnt", int'(bus.gnt), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_status", int'(bus.status), 0);
        check("reset_trig", int'({bus.iic_wr_trig_n, bus.iic_rd_trig_n}), 3);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Both held: alternating grants from requester 0.
        run_txn(2'b11, 2'b00, 0, 2, 10, 0, 0, 0, 0);
        run_txn(2'b11, 2'b00, 0, 2, 10, 0, 1, 0, 0);
        run_txn(2'b11, 2'b00, 0, 2, 10, 0, 1, 0, 0);
        // Write ok with gap, then read nack, start timeout, stuck busy, normal recovery.
        run_txn(2'b01, 2'b01, 0, 2, 30, 0, 1, 0, 0);
        run_txn(2'b10, 2'b00, 0, 2, 30, 1, 1, 0, 0);
        run_txn(2'b01, 2'b01, 1, 2, 30, 0, 1, 0, 0);
        run_txn(2'b10, 2'b10, 2, 2, 30, 0, 1, 0, 0);
        run_txn(2'b11, 2'b11, 0, 3, 20, 0, 1, 1, 0);

        for (int n = 0; n < 24; n++) begin
            int typ;
            int sel;
            sel = int'($urandom_range(0, 19));
            typ = (sel < 2) ? 1 : (sel == 2) ? 2 : 0;
            run_txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), typ,
                    $urandom_range(1, 6), $urandom_range(1, 75), ($urandom_range(0, 3) == 0),
                    1, bit'($urandom_range(0, 1)), 0);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Reset during TRIG, then during GAP; a fresh request pair must go to requester 0.
        run_txn(2'b01, 2'b01, 1, 2, 30, 0, 0, 0, 1);
        run_txn(2'b11, 2'b00, 0, 2, 10, 0, 0, 0, 0);
        bus.req = '0;
        repeat (3) @(negedge clk);
        run_txn(2'b01, 2'b01, 0, 2, 30, 0, 0, 0, 36);
        run_txn(2'b11, 2'b11, 0, 2, 10, 0, 0, 0, 0);
        bus.req = '0;
        repeat (5) @(negedge clk);
        if (q.size() != 0) note_fail("scoreboard_leftover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
